axi_lite_mem_slave: RTL and testbench
=====================================

Name: axi_lite_mem_slave

Overview:
- Parametrised AXI4-Lite memory slave; next generation of the single-width 8-bit slave in the verification environment.
- Adds configurable data width, depth and base address, byte strobes, programmable wait states, and DECERR/SLVERR decode.
- Read and write channels run as independent concurrent FSMs.
- Sits behind the interconnect as the DUT target for the testbench driver, monitor and scoreboard.

Parameters:
- ADDR_WIDTH, 32: address bus width.
- DATA_WIDTH, 32: data bus width; legal values are 8, 16, 32 and 64.
- DEPTH, 16: number of DATA_WIDTH words; must be a power of 2.
- BASE_ADDR, 32'h0: byte address of word 0; aligned to DEPTH*DATA_WIDTH/8.
- WAIT_CYCLES, 0: extra cycles (0..15) inserted before BVALID and before RVALID.

Ports:
- ACLK, in, 1: clock; all logic is on the rising edge.
- ARESET, in, 1: asynchronous reset, active-high.
- AWADDR, in, ADDR_WIDTH: write address.
- AWVALID, in, 1 / AWREADY, out, 1: write address handshake.
- WDATA, in, DATA_WIDTH: write data.
- WSTRB, in, DATA_WIDTH/8: byte enables for WDATA.
- WVALID, in, 1 / WREADY, out, 1: write data handshake.
- BRESP, out, 2: write response.
- BVALID, out, 1 / BREADY, in, 1: write response handshake.
- ARADDR, in, ADDR_WIDTH: read address.
- ARVALID, in, 1 / ARREADY, out, 1: read address handshake.
- RDATA, out, DATA_WIDTH: read data.
- RRESP, out, 2: read response.
- RVALID, out, 1 / RREADY, in, 1: read data handshake.

Behaviour:

Reset
- ARESET high immediately forces all of the following: AWREADY, WREADY, ARREADY, BVALID and RVALID = 0; BRESP and RRESP = OKAY; RDATA = 0; every memory word = 0; both FSMs to idle; wait counters = 0.
- Reset mid-transaction abandons the transaction; no memory write occurs unless the commit edge has already passed.
- The first rising edge after ARESET falls sets AWREADY, WREADY and ARREADY to 1.
- All outputs are registered.

Address decode (shared, combinational)
- LSB = log2(DATA_WIDTH/8).
- DECERR: the address is outside [BASE_ADDR, BASE_ADDR + DEPTH*DATA_WIDTH/8).
- SLVERR: the address is in range but addr[LSB-1:0] != 0. No SLVERR is possible when DATA_WIDTH = 8.
- Otherwise OKAY; word index = (addr - BASE_ADDR) >> LSB.
- DECERR has priority over SLVERR.

Write FSM, states W_IDLE, W_WAIT, W_RESP
- W_IDLE:
  - AWREADY = 1 until AW is captured; WREADY = 1 until W is captured.
  - AW and W may arrive in either order or in the same cycle; each is captured on its own handshake, then its READY drops the next cycle.
  - Once both are captured: go to W_WAIT if WAIT_CYCLES > 0, otherwise go to W_RESP.
- Commit: on the edge that enters W_RESP, write only the bytes with WSTRB[i] = 1 into the decoded word, and only if the decode is OKAY.
  - An error response writes nothing.
  - WSTRB = 0 with OKAY writes nothing and still returns OKAY.
- W_WAIT: counts WAIT_CYCLES edges, then goes to W_RESP.
- W_RESP:
  - BVALID = 1 and BRESP = decode result; both are held stable until BREADY.
  - On the BVALID&BREADY edge: BVALID = 0, return to W_IDLE, and AWREADY/WREADY are reasserted the same edge.
- Minimum latency with WAIT_CYCLES = 0: BVALID rises one cycle after the later of the AW/W handshakes.

Read FSM, states R_IDLE, R_WAIT, R_DATA
- R_IDLE: ARREADY = 1.
- On the AR handshake:
  - Latch the address and response, and sample the memory word. The sample returns the pre-commit value if a write commits on the same edge.
  - ARREADY = 0; go to R_WAIT or R_DATA (as for the write FSM).
- R_DATA:
  - RVALID = 1; RDATA = word if OKAY, else 0; RRESP = decode result.
  - All three are held stable until RREADY.
  - On the handshake edge: RVALID = 0, RDATA = 0, ARREADY = 1, return to R_IDLE.
- Minimum latency: RVALID rises one cycle after the AR handshake.

Concurrency and ordering
- One outstanding transaction per channel.
- Read and write FSMs never stall each other.
- A read whose AR handshake is after the write commit edge returns the new data.

Decomposition:
- Add to axi_lite_pkg:
  - the resp_t constants already present;
  - the wr_state_t enum {W_IDLE, W_WAIT, W_RESP};
  - the rd_state_t enum {R_IDLE, R_WAIT, R_DATA};
  - a parametrised function addr_decode returning resp_t and the word index.
- Sub-module: axi_lite_strb_mem, a DEPTH x DATA_WIDTH array with a byte-masked write port, a synchronous read port and asynchronous clear.

Test Plan (DATA_WIDTH=32, DEPTH=16, BASE_ADDR=0, WAIT_CYCLES=0 unless noted):
1. Write 0x8, data 0xDEADBEEF, WSTRB=4'hF; then read 0x8 -> BRESP=OKAY; RDATA=0xDEADBEEF, RRESP=OKAY; BVALID one cycle after the handshake.
2. Word 0xC = 0x11223344; write data 0xAABBCCDD with WSTRB=4'b0101 -> read returns 0x11BB33DD.
3. W handshake 3 cycles before AW, with BREADY held low for 4 cycles -> BVALID and BRESP stable throughout; AWREADY/WREADY return to 1 on the B handshake edge.
4. Write 0x40 (out of range) -> BRESP=DECERR and memory unchanged. Read 0x42 -> DECERR, RDATA=0. Read 0x6 -> SLVERR.
5. WAIT_CYCLES=3: read 0x0 -> RVALID asserts 4 cycles after the AR handshake. Simultaneous AR 0x4 with a write commit to 0x4 -> read returns the old value.
6. Assert ARESET while in W_RESP and R_DATA -> BVALID = RVALID = 0 immediately; memory reads 0 afterwards; READYs return to 1 one edge after reset release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared types for the AXI4-Lite memory slave.
// Holds response codes, the channel FSM state enums and the address decoder.
package axi_lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    localparam int DEC_AW = 64;
    localparam int DEC_IW = 32;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

    typedef struct packed {
        resp_t             resp;
        logic [DEC_IW-1:0] idx;
    } dec_t;

    // BASE_ADDR is aligned to the window size, so the low bits of the
    // offset equal the low bits of the address itself.
    function automatic dec_t addr_decode(
        input logic [DEC_AW-1:0] addr,
        input logic [DEC_AW-1:0] base,
        input int unsigned       depth,
        input int unsigned       lsb
    );
        dec_t              d;
        logic [DEC_AW-1:0] off;
        logic [DEC_AW-1:0] span;
        logic [DEC_AW-1:0] lmask;
        off   = addr - base;
        span  = DEC_AW'(depth) << lsb;
        lmask = (DEC_AW'(1) << lsb) - DEC_AW'(1);
        d.idx = DEC_IW'(off >> lsb);
        if ((addr < base) || (off >= span)) begin
            d.resp = RESP_DECERR;
        end else if ((off & lmask) != '0) begin
            d.resp = RESP_SLVERR;
        end else begin
            d.resp = RESP_OKAY;
        end
        return d;
    endfunction

endpackage

// File: rtl/axi_lite_strb_mem.sv
// axi_lite_strb_mem: DEPTH x DATA_WIDTH storage, byte-masked write port,
// registered read port with clear; i_rst asynchronously zeroes everything.
module axi_lite_strb_mem #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int IW         = $clog2(DEPTH),
    localparam int NB         = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [IW-1:0]         i_waddr,
    input  logic [NB-1:0]         i_wstrb,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic                  i_rclr,
    input  logic [IW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read-before-write: a read on the commit edge sees the old word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_rclr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite memory target with byte strobes, wait states
// and DECERR/SLVERR decode. Ports: AW/W/B write channels, AR/R read channels.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LAST =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // ---------------- write channel ----------------
    wr_state_t             r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_aw_got;
    logic                  r_w_got;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;
    logic                  r_bvalid;
    resp_t                 r_bresp;
    logic [3:0]            r_wcnt;

    wr_state_t             w_wstate_n;
    logic                  w_awready_n;
    logic                  w_wready_n;
    logic                  w_aw_got_n;
    logic                  w_w_got_n;
    logic [ADDR_WIDTH-1:0] w_awaddr_n;
    logic [DATA_WIDTH-1:0] w_wdata_n;
    logic [NB-1:0]         w_wstrb_n;
    logic                  w_bvalid_n;
    resp_t                 w_bresp_n;
    logic [3:0]            w_wcnt_n;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic [ADDR_WIDTH-1:0] w_cur_addr;
    logic [DATA_WIDTH-1:0] w_cur_data;
    logic [NB-1:0]         w_cur_strb;
    dec_t                  w_wdec;
    logic                  w_widx_ok;
    logic                  w_commit;
    logic                  w_mem_we;

    assign w_aw_hs = AWVALID & r_awready;
    assign w_w_hs  = WVALID & r_wready;

    // Commit may happen on the very edge that captures AW or W.
    assign w_cur_addr = w_aw_hs ? AWADDR : r_awaddr;
    assign w_cur_data = w_w_hs ? WDATA : r_wdata;
    assign w_cur_strb = w_w_hs ? WSTRB : r_wstrb;

    assign w_wdec = addr_decode(DEC_AW'(w_cur_addr), DEC_AW'(BASE_ADDR),
                                DEPTH, LSB);
    assign w_widx_ok = (w_wdec.idx >> IW) == '0;
    assign w_mem_we  = w_commit & (w_wdec.resp == RESP_OKAY) & w_widx_ok;

    always_comb begin
        w_wstate_n  = r_wstate;
        w_awready_n = r_awready;
        w_wready_n  = r_wready;
        w_aw_got_n  = r_aw_got;
        w_w_got_n   = r_w_got;
        w_awaddr_n  = r_awaddr;
        w_wdata_n   = r_wdata;
        w_wstrb_n   = r_wstrb;
        w_bvalid_n  = r_bvalid;
        w_bresp_n   = r_bresp;
        w_wcnt_n    = r_wcnt;
        w_commit    = 1'b0;
        unique case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_aw_got_n = 1'b1;
                    w_awaddr_n = AWADDR;
                end
                if (w_w_hs) begin
                    w_w_got_n = 1'b1;
                    w_wdata_n = WDATA;
                    w_wstrb_n = WSTRB;
                end
                w_awready_n = ~(r_aw_got | w_aw_hs);
                w_wready_n  = ~(r_w_got | w_w_hs);
                if ((r_aw_got | w_aw_hs) && (r_w_got | w_w_hs)) begin
                    w_bresp_n = w_wdec.resp;
                    if (WAIT_CYCLES > 0) begin
                        w_wstate_n = W_WAIT;
                        w_wcnt_n   = 4'd0;
                    end else begin
                        w_wstate_n = W_RESP;
                        w_bvalid_n = 1'b1;
                        w_commit   = 1'b1;
                    end
                end
            end
            W_WAIT: begin
                if (r_wcnt == WAIT_LAST) begin
                    w_wstate_n = W_RESP;
                    w_bvalid_n = 1'b1;
                    w_commit   = 1'b1;
                end else begin
                    w_wcnt_n = r_wcnt + 4'd1;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_wstate_n  = W_IDLE;
                    w_bvalid_n  = 1'b0;
                    w_awready_n = 1'b1;
                    w_wready_n  = 1'b1;
                    w_aw_got_n  = 1'b0;
                    w_w_got_n   = 1'b0;
                end
            end
            default: begin
                w_wstate_n = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_wcnt    <= 4'd0;
        end else begin
            r_wstate  <= w_wstate_n;
            r_awready <= w_awready_n;
            r_wready  <= w_wready_n;
            r_aw_got  <= w_aw_got_n;
            r_w_got   <= w_w_got_n;
            r_awaddr  <= w_awaddr_n;
            r_wdata   <= w_wdata_n;
            r_wstrb   <= w_wstrb_n;
            r_bvalid  <= w_bvalid_n;
            r_bresp   <= w_bresp_n;
            r_wcnt    <= w_wcnt_n;
        end
    end

    // ---------------- read channel ----------------
    rd_state_t  r_rstate;
    logic       r_arready;
    logic       r_rvalid;
    resp_t      r_rresp;
    logic [3:0] r_rcnt;

    rd_state_t  w_rstate_n;
    logic       w_arready_n;
    logic       w_rvalid_n;
    resp_t      w_rresp_n;
    logic [3:0] w_rcnt_n;

    logic       w_ar_hs;
    dec_t       w_rdec;
    logic       w_ridx_ok;
    logic       w_rd_ok;
    logic       w_mem_re;
    logic       w_mem_rclr;

    assign w_ar_hs   = ARVALID & r_arready;
    assign w_rdec    = addr_decode(DEC_AW'(ARADDR), DEC_AW'(BASE_ADDR),
                                   DEPTH, LSB);
    assign w_ridx_ok = (w_rdec.idx >> IW) == '0;
    assign w_rd_ok   = (w_rdec.resp == RESP_OKAY) & w_ridx_ok;

    // The memory's read register doubles as RDATA: loaded on a good AR,
    // zeroed on an error AR and on the R handshake.
    assign w_mem_re   = w_ar_hs & w_rd_ok;
    assign w_mem_rclr = (w_ar_hs & ~w_rd_ok)
                      | ((r_rstate == R_DATA) & RREADY);

    always_comb begin
        w_rstate_n  = r_rstate;
        w_arready_n = r_arready;
        w_rvalid_n  = r_rvalid;
        w_rresp_n   = r_rresp;
        w_rcnt_n    = r_rcnt;
        unique case (r_rstate)
            R_IDLE: begin
                w_arready_n = 1'b1;
                if (w_ar_hs) begin
                    w_arready_n = 1'b0;
                    w_rresp_n   = w_rdec.resp;
                    if (WAIT_CYCLES > 0) begin
                        w_rstate_n = R_WAIT;
                        w_rcnt_n   = 4'd0;
                    end else begin
                        w_rstate_n = R_DATA;
                        w_rvalid_n = 1'b1;
                    end
                end
            end
            R_WAIT: begin
                if (r_rcnt == WAIT_LAST) begin
                    w_rstate_n = R_DATA;
                    w_rvalid_n = 1'b1;
                end else begin
                    w_rcnt_n = r_rcnt + 4'd1;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    w_rstate_n  = R_IDLE;
                    w_rvalid_n  = 1'b0;
                    w_arready_n = 1'b1;
                end
            end
            default: begin
                w_rstate_n = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rcnt    <= 4'd0;
        end else begin
            r_rstate  <= w_rstate_n;
            r_arready <= w_arready_n;
            r_rvalid  <= w_rvalid_n;
            r_rresp   <= w_rresp_n;
            r_rcnt    <= w_rcnt_n;
        end
    end

    // ---------------- storage ----------------
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    axi_lite_strb_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_we    (w_mem_we),
        .i_waddr (w_wdec.idx[IW-1:0]),
        .i_wstrb (w_cur_strb),
        .i_wdata (w_cur_data),
        .i_re    (w_mem_re),
        .i_rclr  (w_mem_rclr),
        .i_raddr (w_rdec.idx[IW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RRESP   = r_rresp;
    assign RDATA   = w_mem_rdata;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: directed bench for axi_lite_mem_slave.
// Instance 0 has no wait states, instance 1 has three.
module tb_axi_lite_mem_slave;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_lite_mem_slave #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .DEPTH       (16),
            .BASE_ADDR   (32'h0),
            .WAIT_CYCLES (g * 3)
        ) u_dut (
            .ACLK    (clk),
            .ARESET  (rst),
            .AWADDR  (awaddr[g]),
            .AWVALID (awvalid[g]),
            .AWREADY (awready[g]),
            .WDATA   (wdata[g]),
            .WSTRB   (wstrb[g]),
            .WVALID  (wvalid[g]),
            .WREADY  (wready[g]),
            .BRESP   (bresp[g]),
            .BVALID  (bvalid[g]),
            .BREADY  (bready[g]),
            .ARADDR  (araddr[g]),
            .ARVALID (arvalid[g]),
            .ARREADY (arready[g]),
            .RDATA   (rdata[g]),
            .RRESP   (rresp[g]),
            .RVALID  (rvalid[g]),
            .RREADY  (rready[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input logic [31:0] a,
                      input logic [31:0] dat, input logic [3:0] s,
                      output logic [1:0] resp, output int lat);
        int n;
        awaddr[d] = a;
        wdata[d] = dat;
        wstrb[d] = s;
        awvalid[d] = 1'b1;
        wvalid[d] = 1'b1;
        n = 0;
        while (!(awready[d] && wready[d]) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("wr_ready_timeout", 64'(n), 64'(0));
        tick();
        awvalid[d] = 1'b0;
        wvalid[d] = 1'b0;
        lat = 0;
        while (!bvalid[d] && lat < 20) begin
            tick();
            lat++;
        end
        resp = bresp[d];
        bready[d] = 1'b1;
        tick();
        bready[d] = 1'b0;
    endtask

    task automatic rd(input int d, input logic [31:0] a,
                      output logic [31:0] dat, output logic [1:0] resp,
                      output int lat);
        int n;
        araddr[d] = a;
        arvalid[d] = 1'b1;
        n = 0;
        while (!arready[d] && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("rd_ready_timeout", 64'(n), 64'(0));
        tick();
        arvalid[d] = 1'b0;
        lat = 0;
        while (!rvalid[d] && lat < 20) begin
            tick();
            lat++;
        end
        dat = rdata[d];
        resp = rresp[d];
        rready[d] = 1'b1;
        tick();
        rready[d] = 1'b0;
    endtask

    logic [31:0] dat;
    logic [1:0]  resp;
    int          lat;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            awaddr[d] = '0;  awvalid[d] = 1'b0;
            wdata[d] = '0;   wstrb[d] = '0;   wvalid[d] = 1'b0;
            bready[d] = 1'b0;
            araddr[d] = '0;  arvalid[d] = 1'b0;
            rready[d] = 1'b0;
        end

        // reset state
        repeat (3) tick();
        chk("rst_awready", awready[0], 1'b0);
        chk("rst_arready", arready[1], 1'b0);
        chk("rst_bvalid", bvalid[0], 1'b0);
        chk("rst_rvalid", rvalid[0], 1'b0);
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_bresp", bresp[0], 2'b00);
        rst = 1'b0;
        chk("rel_awready_still0", awready[0], 1'b0);
        tick();
        chk("rel_awready", awready[0], 1'b1);
        chk("rel_wready", wready[0], 1'b1);
        chk("rel_arready", arready[0], 1'b1);
        chk("rel_arready_w3", arready[1], 1'b1);

        // 1: full-word write and read back
        wr(0, 32'h8, 32'hDEADBEEF, 4'hF, resp, lat);
        chk("t1_bresp", resp, 2'b00);
        chk("t1_blat", 64'(lat), 64'(0));
        rd(0, 32'h8, dat, resp, lat);
        chk("t1_rdata", dat, 32'hDEADBEEF);
        chk("t1_rresp", resp, 2'b00);
        chk("t1_rlat", 64'(lat), 64'(0));
        chk("t1_rdata_clr", rdata[0], 32'h0);

        // 2: partial strobes
        wr(0, 32'hC, 32'h11223344, 4'hF, resp, lat);
        wr(0, 32'hC, 32'hAABBCCDD, 4'b0101, resp, lat);
        chk("t2_bresp", resp, 2'b00);
        rd(0, 32'hC, dat, resp, lat);
        chk("t2_rdata", dat, 32'h11BB33DD);
        wr(0, 32'hC, 32'hFFFFFFFF, 4'b0000, resp, lat);
        chk("t2_nostrb_bresp", resp, 2'b00);
        rd(0, 32'hC, dat, resp, lat);
        chk("t2_nostrb_rdata", dat, 32'h11BB33DD);

        // 3: W three cycles before AW, BREADY held low
        wdata[0] = 32'hCAFEF00D;
        wstrb[0] = 4'hF;
        wvalid[0] = 1'b1;
        tick();
        wvalid[0] = 1'b0;
        chk("t3_wready_drop", wready[0], 1'b0);
        chk("t3_awready_hold", awready[0], 1'b1);
        chk("t3_no_bvalid", bvalid[0], 1'b0);
        tick();
        tick();
        awaddr[0] = 32'h10;
        awvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_bvalid_hold", bvalid[0], 1'b1);
            chk("t3_bresp_hold", bresp[0], 2'b00);
            tick();
        end
        bready[0] = 1'b1;
        tick();
        bready[0] = 1'b0;
        chk("t3_bvalid_drop", bvalid[0], 1'b0);
        chk("t3_awready_back", awready[0], 1'b1);
        chk("t3_wready_back", wready[0], 1'b1);
        rd(0, 32'h10, dat, resp, lat);
        chk("t3_rdata", dat, 32'hCAFEF00D);

        // 4: decode errors
        wr(0, 32'h40, 32'hFFFFFFFF, 4'hF, resp, lat);
        chk("t4_decerr_bresp", resp, 2'b11);
        rd(0, 32'h0, dat, resp, lat);
        chk("t4_word0_untouched", dat, 32'h0);
        rd(0, 32'h42, dat, resp, lat);
        chk("t4_decerr_rresp", resp, 2'b11);
        chk("t4_decerr_rdata", dat, 32'h0);
        rd(0, 32'h6, dat, resp, lat);
        chk("t4_slverr_rresp", resp, 2'b10);
        chk("t4_slverr_rdata", dat, 32'h0);
        wr(0, 32'h9, 32'h0, 4'hF, resp, lat);
        chk("t4_slverr_bresp", resp, 2'b10);
        rd(0, 32'h8, dat, resp, lat);
        chk("t4_slverr_nowrite", dat, 32'hDEADBEEF);

        // 5: three wait states
        wr(1, 32'h4, 32'h12345678, 4'hF, resp, lat);
        chk("t5_blat", 64'(lat), 64'(3));
        rd(1, 32'h0, dat, resp, lat);
        chk("t5_rlat", 64'(lat), 64'(3));
        chk("t5_rdata0", dat, 32'h0);
        awaddr[1] = 32'h4;
        wdata[1] = 32'h9ABCDEF0;
        wstrb[1] = 4'hF;
        awvalid[1] = 1'b1;
        wvalid[1] = 1'b1;
        tick();
        awvalid[1] = 1'b0;
        wvalid[1] = 1'b0;
        tick();
        tick();
        chk("t5_wait_no_bvalid", bvalid[1], 1'b0);
        araddr[1] = 32'h4;
        arvalid[1] = 1'b1;
        tick();
        arvalid[1] = 1'b0;
        chk("t5_commit_bvalid", bvalid[1], 1'b1);
        lat = 0;
        while (!rvalid[1] && lat < 20) begin
            tick();
            lat++;
        end
        chk("t5_coll_rlat", 64'(lat), 64'(3));
        chk("t5_coll_old", rdata[1], 32'h12345678);
        bready[1] = 1'b1;
        rready[1] = 1'b1;
        tick();
        bready[1] = 1'b0;
        rready[1] = 1'b0;
        rd(1, 32'h4, dat, resp, lat);
        chk("t5_new", dat, 32'h9ABCDEF0);

        // 6: reset while in W_RESP and R_DATA
        awaddr[0] = 32'h8;
        wdata[0] = 32'h55555555;
        wstrb[0] = 4'hF;
        awvalid[0] = 1'b1;
        wvalid[0] = 1'b1;
        araddr[0] = 32'h8;
        arvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0;
        wvalid[0] = 1'b0;
        arvalid[0] = 1'b0;
        chk("t6_bvalid", bvalid[0], 1'b1);
        chk("t6_rvalid", rvalid[0], 1'b1);
        chk("t6_same_edge_old", rdata[0], 32'hDEADBEEF);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_bvalid", bvalid[0], 1'b0);
        chk("t6_async_rvalid", rvalid[0], 1'b0);
        chk("t6_async_rdata", rdata[0], 32'h0);
        chk("t6_async_awready", awready[0], 1'b0);
        tick();
        rst = 1'b0;
        chk("t6_rel_arready0", arready[0], 1'b0);
        tick();
        chk("t6_rel_awready", awready[0], 1'b1);
        chk("t6_rel_wready", wready[0], 1'b1);
        chk("t6_rel_arready", arready[0], 1'b1);
        rd(0, 32'h8, dat, resp, lat);
        chk("t6_mem8_zero", dat, 32'h0);
        rd(0, 32'hC, dat, resp, lat);
        chk("t6_memC_zero", dat, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
